// File: rtl/store_narrow_unit.sv
// Store narrowing unit: replicates SB/SH/SW data into byte lanes, builds the byte-enable mask
// and issues one memory write over valid/ready. Define STORE_MISALIGN_TRAP_EN to reject misaligned stores.
module store_narrow_unit #(
  parameter int BIG_ENDIAN     = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_done,
  output logic        st_err
);

  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // mem_valid and its payload stay constant until that edge or a timeout abort.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        st_done_q, st_done_d;
  logic        st_err_q, st_err_d;

  logic [1:0]  off;
  logic [3:0]  be_le;
  logic [3:0]  be_lane;
  logic [31:0] wdata_n;
  logic        illegal;

  always_comb begin
    off     = st_addr[1:0];
    be_le   = 4'b0000;
    wdata_n = 32'd0;
    unique case (st_size)
      2'b00: begin
        wdata_n = {4{st_data[7:0]}};
        be_le   = 4'b0001 << off;
      end
      2'b01: begin
        // Halfword offset is forced to 0 or 2; a trapped misalignment never reaches memory anyway.
        wdata_n = {2{st_data[15:0]}};
        be_le   = 4'b0011 << {off[1], 1'b0};
      end
      2'b10: begin
        wdata_n = st_data;
        be_le   = 4'b1111;
      end
      default: begin
        wdata_n = 32'd0;
        be_le   = 4'b0000;
      end
    endcase
    be_lane = (BIG_ENDIAN != 0) ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;
`ifdef STORE_MISALIGN_TRAP_EN
    illegal = (st_size == 2'b11) ||
              (st_size == 2'b01 && off[0]) ||
              (st_size == 2'b10 && off != 2'b00);
`else
    illegal = (st_size == 2'b11);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    st_done_d   = 1'b0;
    st_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (illegal) begin
            st_err_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            cnt_d       = 32'd0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {st_addr[31:2], 2'b00};
            mem_wdata_d = wdata_n;
            mem_be_d    = be_lane;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d     = IDLE;
          cnt_d       = 32'd0;
          mem_valid_d = 1'b0;
          mem_be_d    = 4'b0000;
          st_done_d   = 1'b1;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          cnt_d       = 32'd0;
          mem_valid_d = 1'b0;
          mem_be_d    = 4'b0000;
          st_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'b0000;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
    end
  end

  // Ready is low while reset is held and comes up on the first cycle after it.
  assign st_ready  = (state_q == IDLE) && !rst;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: a little-endian and a big-endian instance share all inputs and
// are checked each cycle against a lane/byte-range model of the store.
module tb_store_narrow_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [1:0]  st_size = 2'b00;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic        mem_ready = 1'b0;

  logic        le_ready, le_valid, le_done, le_err;
  logic [31:0] le_addr, le_wdata;
  logic [3:0]  le_be;
  logic        be_ready, be_valid, be_done, be_err;
  logic [31:0] be_addr, be_wdata;
  logic [3:0]  be_be;

  int n_vec = 0;
  int n_bad = 0;

  store_narrow_unit #(.BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO)) u_le (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(le_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .mem_valid(le_valid), .mem_ready(mem_ready),
    .mem_addr(le_addr), .mem_wdata(le_wdata), .mem_be(le_be), .st_done(le_done), .st_err(le_err)
  );

  store_narrow_unit #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) u_be (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(be_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .mem_valid(be_valid), .mem_ready(mem_ready),
    .mem_addr(be_addr), .mem_wdata(be_wdata), .mem_be(be_be), .st_done(be_done), .st_err(be_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Status outputs of both instances, packed {valid, ready, done, err}.
  task automatic chk_status(input string tag, input logic v, input logic r, input logic d, input logic e);
    chk({tag, "_le"}, 32'({le_valid, le_ready, le_done, le_err}), 32'({v, r, d, e}));
    chk({tag, "_be"}, 32'({be_valid, be_ready, be_done, be_err}), 32'({v, r, d, e}));
  endtask

  // Reference: the store covers bytes [start, start+n) of the word; lane L carries data byte L mod n.
  function automatic void model(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                                output bit legal, output logic [31:0] w,
                                output logic [3:0] bel, output logic [3:0] beb);
    int n;
    int start;
    legal = (size != 2'b11);
`ifdef STORE_MISALIGN_TRAP_EN
    if (size == 2'b01 && addr[0]) legal = 1'b0;
    if (size == 2'b10 && addr[1:0] != 2'b00) legal = 1'b0;
`endif
    n     = 1 << size;
    start = int'(addr[1:0]);
    start = start - (start % n);
    w   = 32'd0;
    bel = 4'b0000;
    beb = 4'b0000;
    for (int l = 0; l < 4; l++) begin
      w[8*l +: 8] = data[8*(l % n) +: 8];
      if (l >= start && l < start + n) begin
        bel[l]     = 1'b1;
        beb[3 - l] = 1'b1;
      end
    end
  endfunction

  // One store; mem_ready rises after 'stall' cycles of mem_valid (never if stall >= TO).
  task automatic run_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                           input int stall);
    bit          legal;
    logic [31:0] w;
    logic [3:0]  bel, beb;
    int          n_valid;
    bit          done_exp;
    model(size, addr, data, legal, w, bel, beb);
    @(negedge clk);
    chk_status("idle", 1'b0, 1'b1, 1'b0, 1'b0);
    st_valid  = 1'b1;
    st_size   = size;
    st_addr   = addr;
    st_data   = data;
    mem_ready = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
    st_data  = $urandom;
    if (!legal) begin
      chk_status("reject", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("reject_be", 32'({le_be, be_be}), 32'd0);
      return;
    end
    n_valid  = (stall >= TO) ? TO : stall + 1;
    done_exp = (stall < TO);
    for (int c = 0; c < n_valid; c++) begin
      if (c > 0) @(negedge clk);
      chk_status("issue", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("addr_le", le_addr, {addr[31:2], 2'b00});
      chk("addr_be", be_addr, {addr[31:2], 2'b00});
      chk("wdata_le", le_wdata, w);
      chk("wdata_be", be_wdata, w);
      chk("be_le", 32'(le_be), 32'(bel));
      chk("be_be", 32'(be_be), 32'(beb));
      mem_ready = (c == stall);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    chk_status(done_exp ? "done" : "timeout", 1'b0, 1'b1, done_exp, !done_exp);
    chk("be_off", 32'({le_be, be_be}), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", le_addr | be_addr, 32'd0);
    chk("rst_wdata", le_wdata | be_wdata, 32'd0);
    chk("rst_be", 32'({le_be, be_be}), 32'd0);
    rst = 1'b0;

    // directed cases
    run_store(2'b00, 32'h0000_0103, 32'hDEAD_BEEF, 0);
    run_store(2'b01, 32'h0000_0202, 32'h0000_CAFE, 0);
    run_store(2'b10, 32'h0000_0040, 32'h1234_5678, 5);
    run_store(2'b10, 32'h0000_0040, 32'h1234_5678, 100);
    run_store(2'b10, 32'h0000_0080, 32'hA5A5_5A5A, TO - 1);
    run_store(2'b11, 32'h0000_0010, 32'hFFFF_FFFF, 0);
    run_store(2'b01, 32'h0000_0101, 32'h0000_BEEF, 0);
    run_store(2'b10, 32'h0000_0103, 32'h0BAD_F00D, 1);

    // reset on the third cycle of a stalled word store
    @(negedge clk);
    st_valid = 1'b1;
    st_size  = 2'b10;
    st_addr  = 32'h0000_0040;
    st_data  = 32'h1234_5678;
    @(negedge clk);
    st_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_status("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_be", 32'({le_be, be_be}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_status("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    run_store(2'b00, 32'h0000_0001, 32'h0000_0077, 2);

    // randomized stores
    for (int i = 0; i < 40; i++) begin
      run_store(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 20)));
    end

    @(negedge clk);
    chk_status("final", 1'b0, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-path counterpart of the load-path sign extender in the MIPS datapath.
- Takes a 32-bit register value plus store size (SB/SH/SW) and byte address, and narrows/replicates the data into the correct byte lanes with a byte-enable mask.
- Issues the write to data memory over a valid/ready handshake.
- Sits between the execute stage and the data-memory port. Holds the request until memory accepts it or a timeout expires.

Parameters:
- BIG_ENDIAN, 0, lane ordering; 0 = byte address 0 in wdata[7:0], 1 = byte address 0 in wdata[31:24].
- TIMEOUT_CYCLES, 16, max cycles mem_valid waits for mem_ready before abort; 0 = never time out.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request present.
- st_ready  output  1  unit can accept a request (high only in IDLE).
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- st_addr  input  32  byte address.
- st_data  input  32  register value; only low byte/halfword used for SB/SH.
- mem_valid  output  1  write request to memory.
- mem_ready  input  1  memory accepts write.
- mem_addr  output  32  word address, {st_addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables, bit i = byte lane wdata[8i+7:8i].
- st_done  output  1  one-cycle pulse: write accepted.
- st_err  output  1  one-cycle pulse: illegal size, misalignment (if trapped) or timeout; no write completed.

Behaviour:
- Reset values: st_ready=0 during rst, 1 on the first cycle after. mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, st_done=0, st_err=0. State=IDLE. Timeout counter=0.
- Reset mid-ISSUE aborts the write immediately. No st_done/st_err pulse.
- States: IDLE, ISSUE.
- IDLE:
  - st_ready=1.
  - On st_valid & st_ready: register addr/size/data.
  - Legal request -> ISSUE; mem_valid=1 on the next cycle (latency 1).
  - Illegal request (size 11, or misaligned with trap enabled) -> stay IDLE; st_err=1 next cycle; mem_valid stays 0.
- Data replication:
  - byte: wdata={4{d[7:0]}}.
  - half: wdata={2{d[15:0]}}.
  - word: wdata=d.
- Byte enables, little-endian, off=st_addr[1:0]:
  - byte: be=4'b0001<<off.
  - half: be=4'b0011<<off (off 0 or 2).
  - word: be=4'b1111.
- BIG_ENDIAN=1: be bit-reversed (lane 3 = address offset 0).
- ISSUE:
  - mem_valid=1.
  - mem_addr/mem_wdata/mem_be held stable until handshake.
  - Handshake = mem_valid & mem_ready at a rising edge.
  - On handshake: next cycle mem_valid=0, st_done=1, state IDLE.
  - Back-to-back rate: one store per 2 cycles (st_ready returns the cycle st_done pulses).
- Timeout:
  - Counter increments each ISSUE cycle without mem_ready and clears on leaving ISSUE.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with mem_ready low: next cycle mem_valid=0, st_err=1, state IDLE.
  - Handshake on the same cycle as timeout expiry: handshake wins (st_done, not st_err).
- st_done and st_err never assert together. Each lasts exactly one cycle.
- mem_be=0 whenever mem_valid=0.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: halfword with st_addr[0]=1, or word with st_addr[1:0]!=0, is rejected in IDLE with an st_err pulse and no memory write.
- Not defined: misaligned low address bits are forced to alignment (half: off&2'b10; word: off=0). The write proceeds normally, with no error.

Test Plan:
- Reset then SB addr=0x103, data=0xDEADBEEF, mem_ready=1 -> mem_valid on cycle+1, mem_addr=0x100, mem_wdata=0xEFEFEFEF, mem_be=4'b1000; st_done pulse next cycle.
- SH addr=0x202, data=0x0000CAFE, BIG_ENDIAN=0 -> mem_wdata=0xCAFECAFE, mem_be=4'b1100. Repeat with BIG_ENDIAN=1 -> mem_be=4'b0011.
- SW addr=0x40, data=0x12345678, mem_ready low 5 cycles then high -> mem_valid/addr/wdata/be stable for 6 cycles; one st_done; st_ready low throughout.
- SW with mem_ready never asserted, TIMEOUT_CYCLES=16 -> mem_valid drops after 16 cycles; st_err pulses once; st_ready returns high.
- st_size=11 -> st_err pulse, mem_valid never asserts. SH addr=0x101: with STORE_MISALIGN_TRAP_EN -> st_err, no write; without it -> mem_be=4'b0011, st_done.
- rst asserted on the 3rd cycle of a stalled SW -> next cycle mem_valid=0, no st_done/st_err; a new SB is accepted afterwards.
